// File: rtl/c7bbiu.sv
// c7bbiu -- bus interface unit between the c7b core and one external memory port.
//
// Arbitrates ICU line-fill reads against LSU reads and writes, runs exactly one
// memory transaction at a time, and steers the acknowledge and response back to
// whichever requester owns the transaction in flight.
//
// Parameters:
//   FAIR               1 = round-robin between LSU and ICU, 0 = LSU always wins
//
// Ports:
//   clk, resetn        core clock; synchronous active-low reset
//   icu_biu_*          ICU read request/address (held until ack)
//   biu_icu_*          ICU ack pulse, read data valid, read data
//   lsu_biu_rd_*       LSU read request/address (held until ack)
//   lsu_biu_wr_*       LSU write request/address/data/byte enables (held until ack)
//   biu_lsu_*          LSU read ack, write ack, read data valid/data, write done
//   biu_mem_*          registered memory request, write enable, address, data, strobes
//   mem_biu_*          memory accept, read data valid/data, write complete
module c7bbiu #(
    parameter int unsigned FAIR = 1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        icu_biu_req,
    input  logic [31:0] icu_biu_addr,
    output logic        biu_icu_ack,
    output logic        biu_icu_data_valid,
    output logic [63:0] biu_icu_data,

    input  logic        lsu_biu_rd_req,
    input  logic [31:0] lsu_biu_rd_addr,
    output logic        biu_lsu_rd_ack,
    output logic        biu_lsu_data_valid,
    output logic [63:0] biu_lsu_data,

    input  logic        lsu_biu_wr_req,
    input  logic [31:0] lsu_biu_wr_addr,
    input  logic [63:0] lsu_biu_wr_data,
    input  logic [7:0]  lsu_biu_wr_strb,
    output logic        biu_lsu_wr_ack,
    output logic        biu_lsu_write_done,

    output logic        biu_mem_req,
    output logic        biu_mem_we,
    output logic [31:0] biu_mem_addr,
    output logic [63:0] biu_mem_wdata,
    output logic [7:0]  biu_mem_wstrb,
    input  logic        mem_biu_ack,
    input  logic        mem_biu_rvalid,
    input  logic [63:0] mem_biu_rdata,
    input  logic        mem_biu_wdone
);

    typedef enum logic [1:0] {StIdle, StReq, StRdWait, StWrWait} state_e;
    typedef enum logic [1:0] {OwnIcu, OwnLsuRd, OwnLsuWr} owner_e;

    state_e      state_q, state_d;
    owner_e      owner_q;
    logic        last_lsu_q;   // side granted most recently: 1 = LSU, 0 = ICU
    logic        hist_q;       // a grant has happened since reset, so last_lsu_q is meaningful
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;

    // ------------------------------------------------------------------
    // Arbitration (only consumed while idle)
    // ------------------------------------------------------------------
    logic        lsu_any;
    logic        any_req;
    logic        grant_lsu;
    owner_e      lsu_pick;
    owner_e      win_owner;
    logic [31:0] win_addr;
    logic        load;

    assign lsu_any  = lsu_biu_wr_req | lsu_biu_rd_req;
    assign any_req  = lsu_any | icu_biu_req;
    // Inside the LSU a write always beats a read.
    assign lsu_pick = lsu_biu_wr_req ? OwnLsuWr : OwnLsuRd;

    always_comb begin
        grant_lsu = 1'b0;
        if (lsu_any && !icu_biu_req) begin
            grant_lsu = 1'b1;
        end else if (lsu_any && icu_biu_req) begin
            if (FAIR != 0) begin
                // Side not granted last wins; with no history yet the ICU goes first.
                grant_lsu = hist_q && !last_lsu_q;
            end else begin
                grant_lsu = 1'b1;
            end
        end
    end

    assign win_owner = grant_lsu ? lsu_pick : OwnIcu;

    always_comb begin
        win_addr = icu_biu_addr;
        unique case (win_owner)
            OwnIcu:   win_addr = icu_biu_addr;
            OwnLsuRd: win_addr = lsu_biu_rd_addr;
            OwnLsuWr: win_addr = lsu_biu_wr_addr;
            default:  win_addr = icu_biu_addr;
        endcase
    end

    assign load = (state_q == StIdle) && any_req;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req)        state_d = StReq;
            StReq:    if (mem_biu_ack)    state_d = we_q ? StWrWait : StRdWait;
            StRdWait: if (mem_biu_rvalid) state_d = StIdle;
            StWrWait: if (mem_biu_wdone)  state_d = StIdle;
            default:                      state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Acks and completions are combinational from the memory
    // inputs, gated by state and owner so only the owner ever sees them.
    // ------------------------------------------------------------------
    always_comb begin
        biu_icu_ack        = 1'b0;
        biu_lsu_rd_ack     = 1'b0;
        biu_lsu_wr_ack     = 1'b0;
        biu_icu_data_valid = 1'b0;
        biu_lsu_data_valid = 1'b0;
        biu_lsu_write_done = 1'b0;
        if (resetn) begin
            unique case (state_q)
                StReq: begin
                    if (mem_biu_ack) begin
                        biu_icu_ack    = (owner_q == OwnIcu);
                        biu_lsu_rd_ack = (owner_q == OwnLsuRd);
                        biu_lsu_wr_ack = (owner_q == OwnLsuWr);
                    end
                end
                StRdWait: begin
                    if (mem_biu_rvalid) begin
                        biu_icu_data_valid = (owner_q == OwnIcu);
                        biu_lsu_data_valid = (owner_q == OwnLsuRd);
                    end
                end
                StWrWait: begin
                    biu_lsu_write_done = mem_biu_wdone && (owner_q == OwnLsuWr);
                end
                default: ;
            endcase
        end
    end

    // Read data is a plain pass-through; only the valids are qualified.
    assign biu_icu_data = mem_biu_rdata;
    assign biu_lsu_data = mem_biu_rdata;

    // ------------------------------------------------------------------
    // Request registers: loaded only on a grant in idle, so a request that
    // is still high after its ack can never be issued twice.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_q    <= OwnIcu;
            last_lsu_q <= 1'b0;
            hist_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else if (load) begin
            owner_q    <= win_owner;
            last_lsu_q <= grant_lsu;
            hist_q     <= 1'b1;
            req_q      <= 1'b1;
            we_q       <= (win_owner == OwnLsuWr);
            addr_q     <= win_addr & 32'hFFFF_FFF8;
            wdata_q    <= (win_owner == OwnLsuWr) ? lsu_biu_wr_data : 64'h0;
            wstrb_q    <= (win_owner == OwnLsuWr) ? lsu_biu_wr_strb : 8'h0;
        end else if ((state_q == StReq) && mem_biu_ack) begin
            req_q      <= 1'b0;
        end
    end

    assign biu_mem_req   = req_q;
    assign biu_mem_we    = we_q;
    assign biu_mem_addr  = addr_q;
    assign biu_mem_wdata = wdata_q;
    assign biu_mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_c7bbiu.sv
module tb_c7bbiu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        icu_req, rd_req, wr_req;
    logic [31:0] icu_addr, rd_addr, wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic        mem_ack, mem_rvalid, mem_wdone;
    logic [63:0] mem_rdata;
    logic        m0_ack, m0_rvalid, m0_wdone;

    logic        icu_ack, icu_dv, rd_ack, lsu_dv, wr_ack, wr_done;
    logic [63:0] icu_data, lsu_data;
    logic        mreq, mwe;
    logic [31:0] maddr;
    logic [63:0] mwdata;
    logic [7:0]  mwstrb;

    logic        d0_icu_ack, d0_icu_dv, d0_rd_ack, d0_lsu_dv, d0_wr_ack, d0_wr_done;
    logic [63:0] d0_icu_data, d0_lsu_data;
    logic        d0_mreq, d0_mwe;
    logic [31:0] d0_maddr;
    logic [63:0] d0_mwdata;
    logic [7:0]  d0_mwstrb;

    int errors = 0;
    int checks = 0;
    logic icu_rereq;

    c7bbiu #(.FAIR(1)) dut (
        .clk(clk), .resetn(resetn),
        .icu_biu_req(icu_req), .icu_biu_addr(icu_addr),
        .biu_icu_ack(icu_ack), .biu_icu_data_valid(icu_dv), .biu_icu_data(icu_data),
        .lsu_biu_rd_req(rd_req), .lsu_biu_rd_addr(rd_addr),
        .biu_lsu_rd_ack(rd_ack), .biu_lsu_data_valid(lsu_dv), .biu_lsu_data(lsu_data),
        .lsu_biu_wr_req(wr_req), .lsu_biu_wr_addr(wr_addr), .lsu_biu_wr_data(wr_data),
        .lsu_biu_wr_strb(wr_strb), .biu_lsu_wr_ack(wr_ack), .biu_lsu_write_done(wr_done),
        .biu_mem_req(mreq), .biu_mem_we(mwe), .biu_mem_addr(maddr),
        .biu_mem_wdata(mwdata), .biu_mem_wstrb(mwstrb),
        .mem_biu_ack(mem_ack), .mem_biu_rvalid(mem_rvalid), .mem_biu_rdata(mem_rdata),
        .mem_biu_wdone(mem_wdone)
    );

    c7bbiu #(.FAIR(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .icu_biu_req(icu_req), .icu_biu_addr(icu_addr),
        .biu_icu_ack(d0_icu_ack), .biu_icu_data_valid(d0_icu_dv), .biu_icu_data(d0_icu_data),
        .lsu_biu_rd_req(rd_req), .lsu_biu_rd_addr(rd_addr),
        .biu_lsu_rd_ack(d0_rd_ack), .biu_lsu_data_valid(d0_lsu_dv), .biu_lsu_data(d0_lsu_data),
        .lsu_biu_wr_req(wr_req), .lsu_biu_wr_addr(wr_addr), .lsu_biu_wr_data(wr_data),
        .lsu_biu_wr_strb(wr_strb), .biu_lsu_wr_ack(d0_wr_ack), .biu_lsu_write_done(d0_wr_done),
        .biu_mem_req(d0_mreq), .biu_mem_we(d0_mwe), .biu_mem_addr(d0_maddr),
        .biu_mem_wdata(d0_mwdata), .biu_mem_wstrb(d0_mwstrb),
        .mem_biu_ack(m0_ack), .mem_biu_rvalid(m0_rvalid), .mem_biu_rdata(mem_rdata),
        .mem_biu_wdone(m0_wdone)
    );

    task automatic clear_inputs();
        icu_req = 0; rd_req = 0; wr_req = 0;
        icu_addr = 0; rd_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        mem_ack = 0; mem_rvalid = 0; mem_wdone = 0; mem_rdata = 0;
        m0_ack = 0; m0_rvalid = 0; m0_wdone = 0;
        icu_rereq = 0;
    endtask

    // One clock with resetn low; returns #1 into the first cycle after reset.
    task automatic do_reset();
        @(negedge clk);
        resetn = 0;
        clear_inputs();
        @(negedge clk);
        resetn = 1;
        #1;
    endtask

    // Serves one transaction with one wait cycle before ack; drops (or re-issues)
    // the acked request in the cycle after its ack.
    task automatic serve_txn(output logic [31:0] a, output logic we, output logic ok);
        logic ai, ar, aw;
        ok = 0; a = 0; we = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            if (mreq === 1'b1) ok = 1;
        end
        if (!ok) return;
        a = maddr; we = mwe;
        @(negedge clk); mem_ack = 1; #1;
        ai = icu_ack; ar = rd_ack; aw = wr_ack;
        @(negedge clk);
        mem_ack = 0;
        if (ai) begin
            if (icu_rereq) begin icu_addr = icu_addr + 32'h8; icu_rereq = 0; end
            else icu_req = 0;
        end
        if (ar) rd_req = 0;
        if (aw) wr_req = 0;
        if (we) mem_wdone = 1; else begin mem_rvalid = 1; mem_rdata = {$urandom, $urandom}; end
        #1;
        @(negedge clk); mem_wdone = 0; mem_rvalid = 0; #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mreq, mwe, icu_ack, rd_ack, wr_ack, icu_dv, lsu_dv, wr_done} !== 8'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b expected 0",
                {mreq, mwe, icu_ack, rd_ack, wr_ack, icu_dv, lsu_dv, wr_done}); end
        checks++;
        if (maddr !== 32'h0 || mwdata !== 64'h0 || mwstrb !== 8'h0)
            begin errors++; $display("FAIL reset_data: got %h %h %h expected 0", maddr, mwdata,
                mwstrb); end
    endtask

    task automatic test_icu_fetch();
        do_reset();
        @(negedge clk); icu_req = 1; icu_addr = 32'h1C00_0004; #1;
        @(negedge clk); #1;
        checks++;
        if (mreq !== 1'b1 || maddr !== 32'h1C00_0000 || mwe !== 1'b0 || mwstrb !== 8'h0)
            begin errors++; $display("FAIL icu_req: got req=%b addr=%h we=%b strb=%h expected 1 1c000000 0 00",
                mreq, maddr, mwe, mwstrb); end
        @(negedge clk); mem_ack = 1; #1;
        checks++;
        if ({icu_ack, rd_ack, wr_ack} !== 3'b100)
            begin errors++; $display("FAIL icu_ack: got %b expected 100", {icu_ack, rd_ack, wr_ack}); end
        @(negedge clk); mem_ack = 0; icu_req = 0; mem_rvalid = 1;
        mem_rdata = 64'hDEADBEEF_01234567; #1;
        checks++;
        if (icu_dv !== 1'b1 || icu_data !== 64'hDEADBEEF_01234567 || lsu_dv !== 1'b0 || mreq !== 1'b0)
            begin errors++; $display("FAIL icu_data: got dv=%b data=%h lsu_dv=%b req=%b expected 1 deadbeef01234567 0 0",
                icu_dv, icu_data, lsu_dv, mreq); end
        @(negedge clk); mem_rvalid = 0; #1;
    endtask

    task automatic test_lsu_write();
        int ack_n, done_n;
        logic hold_ok;
        do_reset();
        ack_n = 0; done_n = 0; hold_ok = 1;
        @(negedge clk); wr_req = 1; wr_addr = 32'h8000_0010; wr_data = 64'h11223344_55667788;
        wr_strb = 8'h0F; #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ack = (i == 3); #1;
            if (mreq !== 1'b1 || mwe !== 1'b1 || mwstrb !== 8'h0F || maddr !== 32'h8000_0010
                || mwdata !== 64'h11223344_55667788) hold_ok = 0;
            if (wr_ack === 1'b1) ack_n++;
        end
        checks++;
        if (!hold_ok) begin errors++; $display("FAIL wr_hold: got unstable req/we/strb/addr/data expected stable for 4 cycles"); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ack = 0; wr_req = 0; mem_wdone = (i == 1); #1;
            if (wr_ack === 1'b1) ack_n++;
            if (wr_done === 1'b1) done_n++;
        end
        mem_wdone = 0;
        checks++;
        if (ack_n != 1) begin errors++; $display("FAIL wr_ack_pulses: got %0d expected 1", ack_n); end
        checks++;
        if (done_n != 1) begin errors++; $display("FAIL wr_done_pulses: got %0d expected 1", done_n); end
    endtask

    task automatic run_order(input logic rereq, input int n, input logic [31:0] ea [4],
                             input logic ewe [4]);
        logic [31:0] a; logic we, ok;
        do_reset();
        @(negedge clk);
        icu_req = 1; icu_addr = 32'h100;
        rd_req = 1; rd_addr = 32'h200;
        wr_req = 1; wr_addr = 32'h300; wr_data = 64'hA5A5; wr_strb = 8'hFF;
        icu_rereq = rereq;
        #1;
        for (int i = 0; i < n; i++) begin
            serve_txn(a, we, ok);
            checks++;
            if (!ok || a !== ea[i] || we !== ewe[i])
                begin errors++; $display("FAIL order_%0d_%0d: got ok=%b addr=%h we=%b expected %h %b",
                    rereq, i, ok, a, we, ea[i], ewe[i]); end
        end
        clear_inputs();
    endtask

    task automatic test_three_way();
        logic [31:0] ea [4];
        logic        ewe [4];
        ea = '{32'h100, 32'h300, 32'h108, 32'h200}; ewe = '{0, 1, 0, 0};
        run_order(1'b1, 4, ea, ewe);
        ea = '{32'h100, 32'h300, 32'h200, 32'h0}; ewe = '{0, 1, 0, 0};
        run_order(1'b0, 3, ea, ewe);
    endtask

    task automatic test_fair0();
        logic ok;
        do_reset();
        @(negedge clk); icu_req = 1; icu_addr = 32'h400; rd_req = 1; rd_addr = 32'h500; #1;
        for (int t = 0; t < 4; t++) begin
            ok = 0;
            for (int i = 0; i < 10 && !ok; i++) begin
                @(negedge clk); #1;
                if (d0_mreq === 1'b1) ok = 1;
            end
            checks++;
            if (!ok || d0_maddr !== rd_addr || d0_mwe !== 1'b0)
                begin errors++; $display("FAIL fair0_grant_%0d: got ok=%b addr=%h expected %h",
                    t, ok, d0_maddr, rd_addr); end
            if (!ok) break;
            @(negedge clk); m0_ack = 1; #1;
            checks++;
            if ({d0_icu_ack, d0_rd_ack} !== 2'b01)
                begin errors++; $display("FAIL fair0_ack_%0d: got %b expected 01", t, {d0_icu_ack, d0_rd_ack}); end
            @(negedge clk); m0_ack = 0; rd_addr = rd_addr + 32'h8; m0_rvalid = 1;
            mem_rdata = {$urandom, $urandom}; #1;
            checks++;
            if (d0_lsu_dv !== 1'b1 || d0_icu_dv !== 1'b0 || d0_lsu_data !== mem_rdata)
                begin errors++; $display("FAIL fair0_dv_%0d: got lsu=%b icu=%b expected 1 0",
                    t, d0_lsu_dv, d0_icu_dv); end
            @(negedge clk); m0_rvalid = 0; #1;
        end
        clear_inputs();
    endtask

    task automatic test_reset_in_rd_wait();
        do_reset();
        @(negedge clk); icu_req = 1; icu_addr = 32'h2000; #1;
        @(negedge clk); #1;
        @(negedge clk); mem_ack = 1; #1;
        @(negedge clk); mem_ack = 0; icu_req = 0; resetn = 0; #1;
        @(negedge clk); resetn = 1; mem_rvalid = 1; mem_rdata = 64'h1234; #1;
        checks++;
        if ({icu_dv, lsu_dv, wr_done, mreq, mwe} !== 5'b0 || maddr !== 32'h0 || mwstrb !== 8'h0
            || mwdata !== 64'h0)
            begin errors++; $display("FAIL rst_rdwait: got dv=%b%b req=%b addr=%h expected all zero",
                icu_dv, lsu_dv, mreq, maddr); end
        @(negedge clk); mem_rvalid = 0; icu_req = 1; icu_addr = 32'h3000; #1;
        @(negedge clk); icu_req = 1; #1;
        checks++;
        if (mreq !== 1'b1 || maddr !== 32'h3000)
            begin errors++; $display("FAIL rst_idle: got req=%b addr=%h expected 1 3000", mreq, maddr); end
        clear_inputs();
    endtask

    task automatic test_spurious();
        do_reset();
        @(negedge clk); mem_wdone = 1; #1;
        checks++;
        if (wr_done !== 1'b0) begin errors++; $display("FAIL spur_idle: got %b expected 0", wr_done); end
        @(negedge clk); mem_wdone = 0; #1;
        checks++;
        if (mreq !== 1'b0) begin errors++; $display("FAIL spur_idle_state: got req=%b expected 0", mreq); end
        @(negedge clk); icu_req = 1; icu_addr = 32'h40; #1;
        @(negedge clk); #1;
        @(negedge clk); mem_ack = 1; #1;
        @(negedge clk); mem_ack = 0; icu_req = 0; mem_wdone = 1; #1;
        checks++;
        if (wr_done !== 1'b0 || icu_dv !== 1'b0)
            begin errors++; $display("FAIL spur_rdwait: got done=%b dv=%b expected 0 0", wr_done, icu_dv); end
        @(negedge clk); mem_wdone = 0; mem_rvalid = 1; mem_rdata = 64'hCAFE; #1;
        checks++;
        if (icu_dv !== 1'b1) begin errors++; $display("FAIL spur_rdwait_state: got dv=%b expected 1", icu_dv); end
        @(negedge clk); mem_rvalid = 0; #1;
    endtask

    // Randomised traffic against a transaction-level model: requesters hold until
    // acked, a round-robin grant history, and a memory with random latencies.
    task automatic test_random();
        logic        p_icu, p_rd, p_wr;
        logic [31:0] p_ia, p_ra, p_wa;
        logic [63:0] p_wd;
        logic [7:0]  p_ws;
        logic        hist, last_lsu, ai, ar, aw, d_ack, d_rv, d_wd;
        logic [31:0] e_addr;
        logic [7:0]  e_strb;
        logic [2:0]  e_ack, e_val;
        int          own, ph, wcnt, rcnt, lc, w, stall;
        do_reset();
        hist = 0; last_lsu = 0; own = 0; ph = 0; wcnt = 0; rcnt = 0; stall = 0;
        ai = 0; ar = 0; aw = 0; e_addr = 0; e_strb = 0;
        p_icu = 0; p_rd = 0; p_wr = 0; p_ia = 0; p_ra = 0; p_wa = 0; p_wd = 0; p_ws = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (ai) begin icu_req = $urandom_range(0, 1); icu_addr = $urandom; end
            else if (!icu_req && $urandom_range(0, 2) == 0) begin icu_req = 1; icu_addr = $urandom; end
            if (ar) begin rd_req = $urandom_range(0, 1); rd_addr = $urandom; end
            else if (!rd_req && $urandom_range(0, 2) == 0) begin rd_req = 1; rd_addr = $urandom; end
            if (aw || (!wr_req && $urandom_range(0, 3) == 0)) begin
                wr_req = aw ? 1'($urandom_range(0, 1)) : 1'b1;
                wr_addr = $urandom; wr_data = {$urandom, $urandom}; wr_strb = 8'($urandom);
            end
            mem_ack = 0; mem_rvalid = 0; mem_wdone = 0; mem_rdata = {$urandom, $urandom};
            d_ack = 0; d_rv = 0; d_wd = 0;
            if (ph == 1) begin
                if (wcnt == 0) begin mem_ack = 1; d_ack = 1; ph = 2; rcnt = $urandom_range(0, 2); end
                else wcnt--;
            end else if (ph == 2) begin
                if (rcnt == 0) begin
                    if (own == 2) begin mem_wdone = 1; d_wd = 1; end
                    else begin mem_rvalid = 1; d_rv = 1; end
                    ph = 0;
                end else rcnt--;
            end
            // Responses outside the matching wait state must be ignored.
            if (!d_ack && !d_rv && !d_wd && $urandom_range(0, 7) == 0) begin
                if (ph == 2) begin if (own == 2) mem_rvalid = 1; else mem_wdone = 1; end
                else begin mem_rvalid = $urandom_range(0, 1); mem_wdone = !mem_rvalid; end
            end
            #1;
            e_ack = d_ack ? (3'b100 >> own) : 3'b000;
            e_val = d_rv ? ((own == 0) ? 3'b100 : 3'b010) : (d_wd ? 3'b001 : 3'b000);
            checks++;
            if ({icu_ack, rd_ack, wr_ack} !== e_ack)
                begin errors++; $display("FAIL rnd_ack@%0d: got %b expected %b", cyc,
                    {icu_ack, rd_ack, wr_ack}, e_ack); end
            checks++;
            if ({icu_dv, lsu_dv, wr_done} !== e_val)
                begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc,
                    {icu_dv, lsu_dv, wr_done}, e_val); end
            if (d_rv) begin
                checks++;
                if (((own == 0) ? icu_data : lsu_data) !== mem_rdata)
                    begin errors++; $display("FAIL rnd_rdata@%0d: got %h expected %h", cyc,
                        (own == 0) ? icu_data : lsu_data, mem_rdata); end
            end
            if (mreq === 1'b1 && ph == 0) begin
                lc = p_wr ? 2 : (p_rd ? 1 : -1);
                if (p_icu && lc >= 0) w = (hist && !last_lsu) ? lc : 0;
                else w = p_icu ? 0 : lc;
                checks++;
                if (w < 0) begin
                    errors++; $display("FAIL rnd_spurious_req@%0d: got req=1 expected 0", cyc);
                    w = 0;
                end else begin
                    e_addr = ((w == 0) ? p_ia : (w == 1) ? p_ra : p_wa) & 32'hFFFF_FFF8;
                    e_strb = (w == 2) ? p_ws : 8'h0;
                    if (maddr !== e_addr || mwe !== (w == 2) || mwstrb !== e_strb
                        || (w == 2 && mwdata !== p_wd))
                        begin errors++; $display("FAIL rnd_grant@%0d: got addr=%h we=%b strb=%h expected %h %b %h",
                            cyc, maddr, mwe, mwstrb, e_addr, (w == 2), e_strb); end
                end
                own = w; hist = 1; last_lsu = (w != 0); ph = 1; wcnt = $urandom_range(0, 3);
            end else if (mreq === 1'b1) begin
                checks++;
                if (!(ph == 1 || d_ack) || maddr !== e_addr || mwstrb !== e_strb)
                    begin errors++; $display("FAIL rnd_hold@%0d: got addr=%h ph=%0d expected %h",
                        cyc, maddr, ph, e_addr); end
            end
            stall = (ph == 0 && mreq !== 1'b1 && (p_icu || p_rd || p_wr)) ? stall + 1 : 0;
            if (stall > 3) begin
                checks++; errors++; stall = 0;
                $display("FAIL rnd_stall@%0d: got no request expected one", cyc);
            end
            ai = icu_ack; ar = rd_ack; aw = wr_ack;
            p_icu = icu_req; p_rd = rd_req; p_wr = wr_req;
            p_ia = icu_addr; p_ra = rd_addr; p_wa = wr_addr; p_wd = wr_data; p_ws = wr_strb;
        end
        clear_inputs();
    endtask

    initial begin
        resetn = 0;
        clear_inputs();
        test_reset();
        test_icu_fetch();
        test_lsu_write();
        test_three_way();
        test_fair0();
        test_reset_in_rd_wait();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
